// File: rtl/adder_share_arb.sv
// Round-robin arbiter time-sharing one WIDTH-bit adder among NREQ requesters, one registered response slot.
// Optional grant lock enabled by defining ADDER_ARB_LOCK_EN (adds the req_lock port).
module adder_share_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef ADDER_ARB_LOCK_EN
   input  logic [NREQ-1:0]       req_lock,
`endif
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic [IDW-1:0]        rsp_id,
   output logic [15:0]           op_count
);

   localparam logic [IDW:0] NREQ_X = (IDW+1)'(NREQ);

   logic                 r_vld_p0;
   logic [WIDTH-1:0]     r_sum_p0;
   logic                 r_cout_p0;
   logic [IDW-1:0]       r_id_p0;
   logic [15:0]          r_cnt;
   logic [IDW-1:0]       r_ptr;

   logic                 w_can_accept;
   logic                 w_gnt_any;
   logic [IDW-1:0]       w_gnt_idx;
   logic [NREQ-1:0]      w_gnt_onehot;
   logic                 w_accept;
   logic signed [WIDTH-1:0] w_op_a;
   logic signed [WIDTH-1:0] w_op_b;
   logic [WIDTH:0]       w_add;
   logic                 w_lock_req;
   logic                 w_owner_idle;
   logic [IDW-1:0]       w_ptr_next;

   // Unsigned add with carry-out; operands are zero-extended so bit WIDTH is the true carry.
   function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
      logic [IDW:0] t;
      t = {1'b0, idx} + {{IDW{1'b0}}, 1'b1};
      if (t >= NREQ_X) t = '0;
      return t[IDW-1:0];
   endfunction

   // Round-robin search starting at r_ptr; with no requester the index stays at r_ptr.
   always_comb begin
      logic [IDW:0] v_idx;
      w_gnt_any    = 1'b0;
      w_gnt_idx    = r_ptr;
      w_gnt_onehot = '0;
      v_idx        = '0;
      for (int k = 0; k < NREQ; k++) begin
         v_idx = {1'b0, r_ptr} + (IDW+1)'(k);
         if (v_idx >= NREQ_X) v_idx = v_idx - NREQ_X;
         if (!w_gnt_any && req_valid[v_idx[IDW-1:0]]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = v_idx[IDW-1:0];
         end
      end
      if (w_gnt_any) w_gnt_onehot[w_gnt_idx] = 1'b1;
   end

   assign w_can_accept = ~r_vld_p0 | rsp_ready;
   assign w_accept     = w_gnt_any & w_can_accept & ~rst;
   assign req_ready    = w_gnt_onehot & {NREQ{w_can_accept & ~rst}};

   assign w_op_a = req_a[w_gnt_idx*WIDTH +: WIDTH];
   assign w_op_b = req_b[w_gnt_idx*WIDTH +: WIDTH];
   assign w_add  = add_carry(w_op_a, w_op_b);

`ifdef ADDER_ARB_LOCK_EN
   logic r_locked;

   // While locked the owner is r_ptr itself, so it always wins the search.
   assign w_lock_req   = req_lock[w_gnt_idx];
   assign w_owner_idle = r_locked & ~req_valid[r_ptr] & w_can_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_locked <= 1'b0;
      end else if (w_accept) begin
         r_locked <= w_lock_req;
      end else if (w_owner_idle) begin
         r_locked <= 1'b0;
      end
   end
`else
   assign w_lock_req   = 1'b0;
   assign w_owner_idle = 1'b0;
`endif

   always_comb begin
      w_ptr_next = r_ptr;
      if (w_accept) begin
         w_ptr_next = w_lock_req ? w_gnt_idx : wrap_inc(w_gnt_idx);
      end else if (w_owner_idle) begin
         w_ptr_next = wrap_inc(r_ptr);
      end
   end

   // Stage p0: response slot, refilled in the same cycle it drains
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p0  <= 1'b0;
         r_sum_p0  <= '0;
         r_cout_p0 <= 1'b0;
         r_id_p0   <= '0;
         r_cnt     <= '0;
         r_ptr     <= '0;
      end else begin
         r_ptr <= w_ptr_next;
         if (w_accept) begin
            r_vld_p0               <= 1'b1;
            {r_cout_p0, r_sum_p0}  <= w_add;
            r_id_p0                <= w_gnt_idx;
            r_cnt                  <= r_cnt + 16'd1;
         end else if (rsp_ready) begin
            r_vld_p0 <= 1'b0;
         end
      end
   end

   assign rsp_valid = r_vld_p0;
   assign rsp_sum   = r_sum_p0;
   assign rsp_cout  = r_cout_p0;
   assign rsp_id    = r_id_p0;
   assign op_count  = r_cnt;

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin scheduler that time-shares one WIDTH-bit ripple-carry adder (a+b, sum plus carry-out, no carry-in) among NREQ requesters. Accepts at most one operand pair per cycle, registers the adder result into a single response slot tagged with the requester index, and returns it over a valid/ready channel. Sits between client units (accumulators, address generators) and the shared adder instance in the prefix-adder datapath.

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 16: operand/sum width; must match the shared adder instance
- IDW, 2: width of requester index, clog2(NREQ), minimum 1
- clk  in  1  rising-edge clock; only clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_lock  in  NREQ  grant-lock request (present only with ADDER_ARB_LOCK_EN)
- rsp_valid  out  1  response slot full
- rsp_ready  in  1  consumer accepts response
- rsp_sum  out  WIDTH  registered sum, (a+b) mod 2^WIDTH
- rsp_cout  out  1  registered carry-out of a+b
- rsp_id  out  IDW  index of requester that owns the response
- op_count  out  16  accepted-operation counter, wraps at 2^16

## Operation
- Slot states: EMPTY (rsp_valid=0), FULL (rsp_valid=1). EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on rsp_ready with accept (slot refilled) or when rsp_ready=0 (hold).
- can_accept = !rsp_valid | rsp_ready. grant = round-robin pick among req_valid starting at priority pointer ptr; req_ready = grant & {NREQ{can_accept}}. req_ready depends combinationally on req_valid and rsp_ready; requesters must not make req_valid depend on req_ready.
- Accept of requester g: adder fed req_a/req_b slice g; rsp_sum, rsp_cout, rsp_id<=g loaded at the edge; ptr <= (g+1) mod NREQ; op_count += 1.
- No accept: ptr, op_count and slot contents unchanged. Slot contents stable while FULL and rsp_ready=0.
- Adder carries no carry-in; cout = bit WIDTH of a+b. Example: 0xFFFF+0x0001 -> sum 0x0000, cout 1.
- Adder inputs driven with slice of ptr-selected requester when no grant (defined value, no X).

## Timing
- Reset (async assert, sync release): rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, op_count=0, ptr=0 (requester 0 highest priority), lock owner cleared; req_ready all 0 during reset.
- Latency: accept at edge N -> rsp_valid high after edge N with result. Throughput 1 op/cycle while rsp_ready=1.
- Simultaneous drain and accept same cycle: slot replaced, rsp_valid stays 1, no bubble.
- Reset mid-operation discards slot content; no response emitted for in-flight accept.
- op_count wraps 0xFFFF -> 0x0000 without flag.

## Configuration
- ADDER_ARB_LOCK_EN defined: req_lock port present. When requester g is accepted with req_lock[g]=1, g becomes lock owner: ptr is held at g, so g wins every arbitration while req_valid[g]=1. Lock released on the first accept of g with req_lock[g]=0, or on any cycle with req_valid[g]=0 and can_accept=1 (ptr then advances to g+1 mod NREQ). Reset clears owner.
- Not defined: no req_lock port; pure round-robin, ptr always advances past the last granted requester.

## Test plan
- Reset then single request: req_valid=0001, a=0x1234, b=0x4321, rsp_ready=1 -> req_ready=0001, next cycle rsp_valid=1, sum=0x5555, cout=0, id=0, op_count=1.
- Overflow: a=0xFFFF, b=0x0001 from requester 2 -> sum=0x0000, cout=1, id=2.
- All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, rsp_id sequence matches, op_count increments each cycle.
- Backpressure: rsp_ready=0 with slot FULL -> req_ready=0, rsp_* stable for 5 cycles; rsp_ready=1 -> same-cycle refill from next round-robin requester, no bubble.
- Async reset asserted mid-stream with slot FULL -> rsp_valid, op_count, rsp_sum go 0 immediately; after release requester 0 wins first.
- ADDER_ARB_LOCK_EN: requesters 1 and 3 valid, 1 with req_lock=1 for 3 ops -> 1,1,1 granted; lock dropped on 4th -> grant order 1,3,1,3.
